pipeline_hazard_sequencer: RTL

//  Cycle-level sequencer for the 3-stage IF/ID -> ID/EX -> EX/WB pipeline. Tracks in-flight register writes
//  in an 8-entry scoreboard, stalls IF/ID on load-use hazards until memory data returns, selects the ALU

---
 rtl/pipeline_pkg.sv | 26 ++
 rtl/hazard_scoreboard.sv | 50 +++++
 rtl/pipeline_hazard_sequencer.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/pipeline_pkg.sv
// Shared encodings for the pipeline hazard sequencer: opcodes, forward-mux selects and FSM states.
package pipeline_pkg;

    localparam int REG_W = 3;

    localparam logic [1:0] OP_ALU    = 2'b00;
    localparam logic [1:0] OP_LOAD   = 2'b01;
    localparam logic [1:0] OP_BRANCH = 2'b10;
    localparam logic [1:0] OP_NOP    = 2'b11;

    localparam logic [1:0] FWD_RF   = 2'b00;
    localparam logic [1:0] FWD_EXWB = 2'b01;
    localparam logic [1:0] FWD_MEM  = 2'b10;

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_LOAD_WAIT = 2'd1,
        ST_FLUSH     = 2'd2
    } state_t;

    // Register 0 is hardwired, so writes to it are never tracked.
    function automatic logic writes_reg(input logic [1:0] op, input logic [REG_W-1:0] dest);
        return !(op == OP_BRANCH || op == OP_NOP) && (dest != '0);
    endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Pending-write scoreboard: one pending bit per register plus a flag marking bits owned by a LOAD.
module hazard_scoreboard
#(
    parameter int NUM_REGS = 8,
    parameter int IDX_W    = 3
)
(
    input  logic                clk,
    input  logic                reset,
    input  logic                set_en,
    input  logic [IDX_W-1:0]    set_idx,
    input  logic                set_load,
    input  logic                clr_en,
    input  logic [IDX_W-1:0]    clr_idx,
    input  logic                clr_loads,
    output logic [NUM_REGS-1:0] pending,
    output logic [NUM_REGS-1:0] load_flag
);

    logic [NUM_REGS-1:0] pending_n;
    logic [NUM_REGS-1:0] flag_n;

    // An ALU retire never clears a bit a LOAD owns; a same-cycle set always wins.
    always_comb begin
        pending_n = pending;
        flag_n    = load_flag;
        if (clr_loads) begin
            pending_n = pending_n & ~load_flag;
            flag_n    = '0;
        end
        if (clr_en && !load_flag[clr_idx]) begin
            pending_n[clr_idx] = 1'b0;
        end
        if (set_en) begin
            pending_n[set_idx] = 1'b1;
            flag_n[set_idx]    = set_load;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pending   <= '0;
            load_flag <= '0;
        end else begin
            pending   <= pending_n;
            load_flag <= flag_n;
        end
    end

endmodule

// File: rtl/pipeline_hazard_sequencer.sv
// Stall/flush/forward sequencer for the 3-stage pipeline. Optional HAZARD_STATS_EN adds
// saturating stall_cycles / flush_count outputs.
module pipeline_hazard_sequencer
    import pipeline_pkg::*;
#(
    parameter int LOAD_LAT = 2,
    parameter int NUM_REGS = 8
)
(
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [1:0]       id_opcode,
    input  logic [REG_W-1:0] id_src_reg,
    input  logic [REG_W-1:0] id_dest_reg,
    input  logic             ex_branch_taken,
    input  logic             mem_data_valid,
    output logic             if_id_stall,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic [1:0]       alu_fwd_sel,
    output logic             busy
`ifdef HAZARD_STATS_EN
    ,
    output logic [15:0]      stall_cycles,
    output logic [15:0]      flush_count
`endif
);

    state_t state;
    state_t next_state;

    logic [NUM_REGS-1:0] pending;
    logic [NUM_REGS-1:0] load_flag;
    logic [2:0]          load_cnt;
    logic                src_live, load_hit, load_stall, issue, set_en;
    logic                stall_d, iflush_d, exflush_d;

    logic                exwb_vld_p1, exwb_alu_p1, ret_vld_p1;
    logic [REG_W-1:0]    exwb_dest_p1;
    logic                alu_ret_vld_p2;
    logic [REG_W-1:0]    alu_ret_dest_p2;

    assign src_live   = id_valid && (id_opcode != OP_NOP) && (id_src_reg != '0);
    assign load_hit   = src_live && pending[id_src_reg] && load_flag[id_src_reg];
    assign load_stall = load_hit && !mem_data_valid;
    assign issue      = (state == ST_RUN) && id_valid && (id_opcode != OP_NOP)
                        && !ex_branch_taken && !load_stall;
    assign set_en     = issue && writes_reg(id_opcode, id_dest_reg);

    hazard_scoreboard #(.NUM_REGS(NUM_REGS), .IDX_W(REG_W)) u_scoreboard (
        .clk       (clk),
        .reset     (reset),
        .set_en    (set_en),
        .set_idx   (id_dest_reg),
        .set_load  (id_opcode == OP_LOAD),
        .clr_en    (alu_ret_vld_p2),
        .clr_idx   (alu_ret_dest_p2),
        .clr_loads (mem_data_valid),
        .pending   (pending),
        .load_flag (load_flag)
    );

    always_comb begin
        next_state = state;
        case (state)
            ST_RUN: begin
                if (ex_branch_taken)  next_state = ST_FLUSH;
                else if (load_stall)  next_state = ST_LOAD_WAIT;
            end
            ST_LOAD_WAIT: begin
                if (ex_branch_taken)     next_state = ST_FLUSH;
                else if (mem_data_valid) next_state = ST_RUN;
            end
            default: next_state = ST_RUN;
        endcase
    end

    always_comb begin
        stall_d   = (next_state == ST_LOAD_WAIT);
        iflush_d  = (next_state == ST_FLUSH);
        exflush_d = (next_state != ST_RUN);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_RUN;
            if_id_stall <= 1'b0;
            if_id_flush <= 1'b0;
            id_ex_flush <= 1'b0;
        end else begin
            state       <= next_state;
            if_id_stall <= stall_d;
            if_id_flush <= iflush_d;
            id_ex_flush <= exflush_d;
        end
    end

    // Issue -> EX/WB (p1) -> ALU retire (p2); ret_vld_p1 marks the cycle after load data returned.
    always_ff @(posedge clk) begin
        if (reset) begin
            exwb_vld_p1    <= 1'b0;
            ret_vld_p1     <= 1'b0;
            alu_ret_vld_p2 <= 1'b0;
            load_cnt       <= '0;
        end else begin
            exwb_vld_p1    <= set_en;
            ret_vld_p1     <= (state == ST_LOAD_WAIT) && (next_state == ST_RUN);
            alu_ret_vld_p2 <= exwb_vld_p1 && exwb_alu_p1;
            if (state == ST_RUN && next_state == ST_LOAD_WAIT) begin
                load_cnt <= 3'(LOAD_LAT);
            end else if (next_state != ST_LOAD_WAIT) begin
                load_cnt <= '0;
            end else if (load_cnt != '0) begin
                load_cnt <= load_cnt - 3'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        exwb_alu_p1     <= (id_opcode == OP_ALU);
        exwb_dest_p1    <= id_dest_reg;
        alu_ret_dest_p2 <= exwb_dest_p1;
    end

    always_comb begin
        alu_fwd_sel = FWD_RF;
        if (state == ST_RUN && !ex_branch_taken && src_live) begin
            if (ret_vld_p1 || (load_hit && mem_data_valid)) begin
                alu_fwd_sel = FWD_MEM;
            end else if (exwb_vld_p1 && exwb_alu_p1 && (exwb_dest_p1 == id_src_reg)) begin
                alu_fwd_sel = FWD_EXWB;
            end
        end
    end

    assign busy = (|pending) || (state == ST_LOAD_WAIT) || (load_cnt != '0);

`ifdef HAZARD_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (if_id_stall && stall_cycles != 16'hFFFF) begin
                stall_cycles <= stall_cycles + 16'd1;
            end
            if (next_state == ST_FLUSH && state != ST_FLUSH && flush_count != 16'hFFFF) begin
                flush_count <= flush_count + 16'd1;
            end
        end
    end
`endif

endmodule
